// File: rtl/mem_port_arbiter.sv
// Two-master (CPU / DMA) front end for a single-port synchronous RAM.
// DMA wins collisions, but a run-length guard hands the port to a waiting CPU.
module mem_port_arbiter #(
   parameter int p_ADDR_BITS   = 16,
   parameter int p_DATA_BITS   = 8,
   parameter int p_DMA_MAX_RUN = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cpu_req_valid,
   output logic                   cpu_req_ready,
   input  logic                   cpu_req_wen,
   input  logic [p_ADDR_BITS-1:0] cpu_req_addr,
   input  logic [p_DATA_BITS-1:0] cpu_req_wdata,
   output logic                   cpu_resp_valid,
   output logic [p_DATA_BITS-1:0] cpu_resp_rdata,
   input  logic                   dma_req_valid,
   output logic                   dma_req_ready,
   input  logic                   dma_req_wen,
   input  logic [p_ADDR_BITS-1:0] dma_req_addr,
   input  logic [p_DATA_BITS-1:0] dma_req_wdata,
   output logic                   dma_resp_valid,
   output logic [p_DATA_BITS-1:0] dma_resp_rdata,
   output logic [p_ADDR_BITS-1:0] mem_addr,
   output logic                   mem_ren,
   output logic                   mem_wen,
   output logic [p_DATA_BITS-1:0] mem_data,
   input  logic [p_DATA_BITS-1:0] mem_q
);

   localparam int               RUN_W   = $clog2(p_DMA_MAX_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(p_DMA_MAX_RUN);

   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

   logic [RUN_W-1:0] run_cnt;
   owner_t           resp_owner;
   logic             resp_is_read;
   logic             cpu_starved;
   logic             grant_dma;
   logic             grant_cpu;

   // Grants are gated by rst_n so the RAM sees no strobes while reset is held.
   assign cpu_starved   = cpu_req_valid && (run_cnt == RUN_MAX);
   assign grant_dma     = rst_n && dma_req_valid && !cpu_starved;
   assign grant_cpu     = rst_n && cpu_req_valid && !grant_dma;
   assign dma_req_ready = grant_dma;
   assign cpu_req_ready = grant_cpu;

   always_comb begin
      mem_addr = '0;
      mem_data = '0;
      mem_wen  = 1'b0;
      mem_ren  = 1'b0;
      if (grant_dma) begin
         mem_addr = dma_req_addr;
         mem_data = dma_req_wdata;
         mem_wen  = dma_req_wen;
         mem_ren  = !dma_req_wen;
      end else if (grant_cpu) begin
         mem_addr = cpu_req_addr;
         mem_data = cpu_req_wdata;
         mem_wen  = cpu_req_wen;
         mem_ren  = !cpu_req_wen;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt      <= '0;
         resp_owner   <= OWN_NONE;
         resp_is_read <= 1'b0;
      end else begin
         // Counts only DMA wins the CPU actually waited through.
         if (!cpu_req_valid || grant_cpu)
            run_cnt <= '0;
         else if (grant_dma && run_cnt != RUN_MAX)
            run_cnt <= run_cnt + 1'b1;

         if (grant_dma) begin
            resp_owner   <= OWN_DMA;
            resp_is_read <= !dma_req_wen;
         end else if (grant_cpu) begin
            resp_owner   <= OWN_CPU;
            resp_is_read <= !cpu_req_wen;
         end else begin
            resp_owner   <= OWN_NONE;
            resp_is_read <= 1'b0;
         end
      end
   end

   // RAM q is valid exactly in the cycle the registered owner points at.
   assign cpu_resp_valid = (resp_owner == OWN_CPU);
   assign dma_resp_valid = (resp_owner == OWN_DMA);
   assign cpu_resp_rdata = (cpu_resp_valid && resp_is_read) ? mem_q : '0;
   assign dma_resp_rdata = (dma_resp_valid && resp_is_read) ? mem_q : '0;

endmodule
